// File: rtl/execute_stage_m_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared encodings for the RV32IM execute stage: ALU ops,
//                mul/div ops (Funct3), forward selects, branch conditions
//                and the iterative mul/div state machine states.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_LUI  = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // First operand is treated as two's complement for these ops.
  function automatic logic md_a_signed(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // Second operand is treated as two's complement for these ops.
  function automatic logic md_b_signed(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_m_if.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_m_if
//  Description : ID/EX inputs, forwarding inputs, fetch redirect / stall
//                outputs and EX/MEM register outputs of the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_m_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RdE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            JumpE;
  logic            JalrE;
  logic            BranchE;
  logic            ALUSrcE;
  logic            MulDivE;
  logic [1:0]      ResultSrcE;
  logic [3:0]      ALUControlE;
  logic [2:0]      Funct3E;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;
  logic            FlushE;
  logic [XLEN-1:0] PCTargetE;
  logic            PCSrcE;
  logic            BusyE;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;
  logic [4:0]      RdM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;

  // Pipeline side that feeds the stage and consumes its results.
  modport master (
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, RegWriteE, MemWriteE,
           JumpE, JalrE, BranchE, ALUSrcE, MulDivE, ResultSrcE, ALUControlE,
           Funct3E, ForwardAE, ForwardBE, ResultW, FlushE,
    input  PCTargetE, PCSrcE, BusyE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, ResultSrcM
  );

  // The execute stage itself.
  modport slave (
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, RegWriteE, MemWriteE,
           JumpE, JalrE, BranchE, ALUSrcE, MulDivE, ResultSrcE, ALUControlE,
           Funct3E, ForwardAE, ForwardBE, ResultW, FlushE,
    output PCTargetE, PCSrcE, BusyE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, ResultSrcM
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage_m_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Iterative RV32M multiply/divide. Shift-add multiply and
//                restoring divide on operand magnitudes, one bit per cycle,
//                with the sign applied on the way out. Divide-by-zero and
//                signed overflow finish without iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  muldiv_op_e      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e   r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;    // product high half / partial remainder
  logic [XLEN-1:0] r_lo;    // multiplier -> product low half / quotient
  logic [XLEN-1:0] r_opnd;  // multiplicand / divisor magnitude
  muldiv_op_e      r_op;
  logic            r_neg;   // negate the selected result at the end
  logic            r_spec;  // r_lo already holds the final special result

  logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_spec;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res;
  logic [XLEN:0]   w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_q, w_r;

  // Operand magnitudes and the two divide corner cases seen at issue.
  always_comb begin
    w_a_neg    = md_a_signed(op) & a[XLEN-1];
    w_b_neg    = md_b_signed(op) & b[XLEN-1];
    w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
    w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
    w_div0     = op[2] & (b == '0);
    w_ovf      = ((op == MD_DIV) || (op == MD_REM)) &
                 (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    w_spec     = w_div0 | w_ovf;
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = ((op == MD_DIV) || (op == MD_DIVU)) ? {XLEN{1'b1}} : a;
    else if (w_ovf)
      w_spec_res = (op == MD_DIV) ? a : '0;
  end

  // One iteration of either algorithm.
  always_comb begin
    w_sum   = {1'b0, r_hi} + {1'b0, r_opnd};
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_opnd};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = start & ~kill & (r_state != DONE);
    done   = (r_state == DONE);
    case (r_state)
      IDLE:    if (start & ~kill) w_next = w_spec ? DONE : RUN;
      RUN:     if (kill) w_next = IDLE;
               else if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latch at issue, then one shift-add / restoring step per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_op   <= MD_MUL;
      r_neg  <= 1'b0;
      r_spec <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start & ~kill) begin
            r_op   <= op;
            r_cnt  <= CW'(XLEN-1);
            r_hi   <= '0;
            r_lo   <= w_spec ? w_spec_res : w_a_mag;
            r_opnd <= w_b_mag;
            r_spec <= w_spec;
            // Remainder takes the dividend's sign; everything else the XOR.
            r_neg  <= ((op == MD_REM) || (op == MD_REMU)) ? w_a_neg : (w_a_neg ^ w_b_neg);
          end
        end
        RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_op[2]) begin
            if (w_shift >= {1'b0, r_opnd}) begin
              r_hi <= w_diff[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
              r_hi <= w_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            if (r_lo[0]) {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
            else         {r_hi, r_lo} <= {1'b0, r_hi, r_lo[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up and result selection.
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
    w_q      = r_neg ? (~r_lo + 1'b1) : r_lo;
    w_r      = r_neg ? (~r_hi + 1'b1) : r_hi;
    result   = '0;
    if (r_spec) begin
      result = r_lo;
    end else begin
      case (r_op)
        MD_MUL:                      result = w_prod_s[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod_s[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:             result = w_q;
        MD_REM, MD_REMU:             result = w_r;
        default:                     result = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_stage_m.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_m
//  Description : RV32IM execute stage: operand forwarding, ALU, branch
//                comparator, JAL/JALR target, iterative mul/div with stall
//                request, and the EX/MEM pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_m
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  execute_stage_m_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] w_srca, w_write_data, w_srcb, w_alu_result;
  logic [XLEN-1:0] w_md_result, w_ex_result, w_target_sum;
  logic [SHW-1:0]  w_shamt;
  logic            w_cond, w_busy, w_md_done;

  logic [XLEN-1:0] r_alu_result_m, r_write_data_m, r_pc_plus4_m;
  logic [4:0]      r_rd_m;
  logic            r_reg_write_m, r_mem_write_m;
  logic [1:0]      r_result_src_m;

  // Forwarding muxes; select 11 falls back to the register file value.
  always_comb begin
    case (fwd_sel_e'(bus.ForwardAE))
      FWD_WB:  w_srca = bus.ResultW;
      FWD_MEM: w_srca = r_alu_result_m;
      default: w_srca = bus.RD1E;
    endcase
    case (fwd_sel_e'(bus.ForwardBE))
      FWD_WB:  w_write_data = bus.ResultW;
      FWD_MEM: w_write_data = r_alu_result_m;
      default: w_write_data = bus.RD2E;
    endcase
    w_srcb  = bus.ALUSrcE ? bus.ImmExtE : w_write_data;
    w_shamt = w_srcb[SHW-1:0];
  end

  // ALU; unused encodings produce zero.
  always_comb begin
    case (alu_op_e'(bus.ALUControlE))
      ALU_ADD:  w_alu_result = w_srca + w_srcb;
      ALU_SUB:  w_alu_result = w_srca - w_srcb;
      ALU_AND:  w_alu_result = w_srca & w_srcb;
      ALU_OR:   w_alu_result = w_srca | w_srcb;
      ALU_XOR:  w_alu_result = w_srca ^ w_srcb;
      ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
      ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (w_srca < w_srcb)};
      ALU_SLL:  w_alu_result = w_srca << w_shamt;
      ALU_SRL:  w_alu_result = w_srca >> w_shamt;
      ALU_SRA:  w_alu_result = $signed(w_srca) >>> w_shamt;
      ALU_LUI:  w_alu_result = w_srcb;
      default:  w_alu_result = '0;
    endcase
  end

  // Branch comparator on the forwarded register operands.
  always_comb begin
    case (bus.Funct3E)
      BR_EQ:   w_cond = (w_srca == w_write_data);
      BR_NE:   w_cond = (w_srca != w_write_data);
      BR_LT:   w_cond = ($signed(w_srca) <  $signed(w_write_data));
      BR_GE:   w_cond = ($signed(w_srca) >= $signed(w_write_data));
      BR_LTU:  w_cond = (w_srca <  w_write_data);
      BR_GEU:  w_cond = (w_srca >= w_write_data);
      default: w_cond = 1'b0;
    endcase
  end

  // Jump/branch target and fetch redirect.
  always_comb begin
    w_target_sum  = (bus.JalrE ? w_srca : bus.PCE) + bus.ImmExtE;
    bus.PCTargetE = bus.JalrE ? {w_target_sum[XLEN-1:1], 1'b0} : w_target_sum;
    bus.PCSrcE    = ~bus.FlushE & ((bus.BranchE & w_cond) | bus.JumpE);
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.MulDivE),
    .kill   (bus.FlushE),
    .op     (muldiv_op_e'(bus.Funct3E)),
    .a      (w_srca),
    .b      (w_write_data),
    .busy   (w_busy),
    .done   (w_md_done),
    .result (w_md_result)
  );

  assign bus.BusyE  = w_busy;
  assign w_ex_result = (bus.MulDivE & w_md_done) ? w_md_result : w_alu_result;

  // EX/MEM register: bubble on flush or stall, data fields hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_pc_plus4_m   <= '0;
      r_rd_m         <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= '0;
    end else if (bus.FlushE | w_busy) begin
      r_rd_m         <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= '0;
    end else begin
      r_alu_result_m <= w_ex_result;
      r_write_data_m <= w_write_data;
      r_pc_plus4_m   <= bus.PCPlus4E;
      r_rd_m         <= bus.RdE;
      r_reg_write_m  <= bus.RegWriteE;
      r_mem_write_m  <= bus.MemWriteE;
      r_result_src_m <= bus.ResultSrcE;
    end
  end

  assign bus.ALUResultM = r_alu_result_m;
  assign bus.WriteDataM = r_write_data_m;
  assign bus.PCPlus4M   = r_pc_plus4_m;
  assign bus.RdM        = r_rd_m;
  assign bus.RegWriteM  = r_reg_write_m;
  assign bus.MemWriteM  = r_mem_write_m;
  assign bus.ResultSrcM = r_result_src_m;

endmodule
`default_nettype wire
